// File: rtl/spi_frame_scheduler_pkg.sv
// Shared types and defaults for the UART-to-SPI frame scheduler.
package spi_frame_scheduler_pkg;

  localparam int unsigned BYTES_PER_WORD_DEF = 3;
  localparam int unsigned WORD_W_DEF         = 8 * BYTES_PER_WORD_DEF;

  // SCK half period in clk cycles; the inter-frame gap is one full SCK period.
  localparam int unsigned SPI_CLK_DIV        = 25;
  localparam int unsigned GAP_CYCLES_DEF     = 2 * SPI_CLK_DIV;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD,
    RDWAIT,
    XFER,
    WAITDONE,
    GAP
  } state_t;

endpackage

// File: rtl/spi_frame_scheduler_word_packer.sv
// Packs UART bytes MSB-first into a word; flags the byte that completes a word.
module word_packer
  import spi_frame_scheduler_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int unsigned WORD_W         = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic [7:0]        din,
  output logic [WORD_W-1:0] word_next_c,
  output logic              word_done_c
);

  localparam int unsigned IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [IDX_W-1:0]  byte_idx;
  // Only the older bytes are kept; the newest byte comes straight from din.
  logic [WORD_W-9:0] shreg;

  assign word_next_c = {shreg, din};
  assign word_done_c = shift && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
      shreg    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      shreg    <= '0;
    end else if (shift) begin
      shreg    <= word_next_c[WORD_W-9:0];
      byte_idx <= word_done_c ? '0 : byte_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/spi_frame_scheduler.sv
// Loads UART bytes into frame memory as words, then replays them to the SPI
// transmitter with a fixed inter-frame gap.
module spi_frame_scheduler
  import spi_frame_scheduler_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int unsigned WORD_W         = WORD_W_DEF,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              tx_valid,
  output logic [WORD_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              tx_done,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              send_done,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  state_t            state;
  logic [CNT_W-1:0]  rd_ptr;
  logic [GAP_W-1:0]  gap_cnt;
  logic              rd_settle;

  logic              full_c;
  logic              pack_clear_c;
  logic              pack_shift_c;
  logic              word_done_c;
  logic [WORD_W-1:0] word_next_c;

  assign full_c       = (word_count == CNT_W'(DEPTH));
  assign pack_clear_c = (state != LOAD);
  assign pack_shift_c = (state == LOAD) && load_en && rx_valid && !full_c;

  word_packer #(
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .WORD_W         (WORD_W)
  ) u_word_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (pack_clear_c),
    .shift       (pack_shift_c),
    .din         (rx_byte),
    .word_next_c (word_next_c),
    .word_done_c (word_done_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      gap_cnt    <= '0;
      rd_settle  <= 1'b0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      mem_raddr  <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      word_count <= '0;
      busy       <= 1'b0;
      send_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      send_done <= 1'b0;
      case (state)
        // load_en takes priority over a coincident start
        IDLE: begin
          if (load_en) begin
            state      <= LOAD;
            busy       <= 1'b1;
            word_count <= '0;
            overflow   <= 1'b0;
          end else if (start && (word_count != '0)) begin
            state  <= RD;
            busy   <= 1'b1;
            rd_ptr <= '0;
          end
        end
        LOAD: begin
          if (!load_en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rx_valid) begin
            if (full_c) begin
              overflow <= 1'b1;
            end else if (word_done_c) begin
              mem_we     <= 1'b1;
              mem_waddr  <= word_count[ADDR_W-1:0];
              mem_wdata  <= word_next_c;
              word_count <= word_count + CNT_W'(1);
            end
          end
        end
        RD: begin
          mem_raddr <= rd_ptr[ADDR_W-1:0];
          rd_settle <= 1'b0;
          state     <= RDWAIT;
        end
        // one cycle for the memory to sample the address, one for data out
        RDWAIT: begin
          if (rd_settle) begin
            tx_data  <= mem_rdata;
            tx_valid <= 1'b1;
            state    <= XFER;
          end else begin
            rd_settle <= 1'b1;
          end
        end
        XFER: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= WAITDONE;
          end
        end
        WAITDONE: begin
          if (tx_done) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            rd_ptr <= rd_ptr + CNT_W'(1);
            if ((rd_ptr + CNT_W'(1)) < word_count) begin
              state <= RD;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              send_done <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Randomized self-checking bench for spi_frame_scheduler with a byte-level load
// model and a word-level send model.
module tb_spi_frame_scheduler;

  localparam int unsigned BPW      = 3;
  localparam int unsigned WW       = 24;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned AW       = 4;
  localparam int unsigned GAP      = 50;
  localparam int unsigned SPI_BITS = 24;
  localparam int unsigned SCK_DIV  = 2;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [WW-1:0] mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [WW-1:0] mem_rdata;
  logic          tx_valid;
  logic [WW-1:0] tx_data;
  logic          tx_ready = 1'b0;
  logic          tx_done = 1'b0;
  logic [AW:0]   word_count;
  logic          busy;
  logic          send_done;
  logic          overflow;

  spi_frame_scheduler #(
    .BYTES_PER_WORD (BPW),
    .WORD_W         (WW),
    .DEPTH          (DEPTH),
    .ADDR_W         (AW),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .word_count (word_count),
    .busy       (busy),
    .send_done  (send_done),
    .overflow   (overflow)
  );

  always #10 clk = ~clk;

  // Frame memory with one-cycle synchronous read.
  logic [WW-1:0] mem_model [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem_model[mem_waddr] <= mem_wdata;
    mem_rdata <= mem_model[mem_raddr];
  end

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [WW-1:0] exp_mem [DEPTH];
  int            exp_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_mem_we"},     32'(mem_we),     32'(0));
    check_eq({pfx, "_mem_waddr"},  32'(mem_waddr),  32'(0));
    check_eq({pfx, "_mem_wdata"},  32'(mem_wdata),  32'(0));
    check_eq({pfx, "_mem_raddr"},  32'(mem_raddr),  32'(0));
    check_eq({pfx, "_tx_valid"},   32'(tx_valid),   32'(0));
    check_eq({pfx, "_tx_data"},    32'(tx_data),    32'(0));
    check_eq({pfx, "_word_count"}, 32'(word_count), 32'(0));
    check_eq({pfx, "_busy"},       32'(busy),       32'(0));
    check_eq({pfx, "_send_done"},  32'(send_done),  32'(0));
    check_eq({pfx, "_overflow"},   32'(overflow),   32'(0));
  endtask

  // One load session; every byte is checked against the packing rule.
  task automatic load_session(input bq_t bytes);
    int            n;
    int            nw;
    logic [WW-1:0] w;
    load_en = 1'b1;
    @(negedge clk);
    check_eq("load_entry_busy",  32'(busy),       32'(1));
    check_eq("load_entry_count", 32'(word_count), 32'(0));
    check_eq("load_entry_ovf",   32'(overflow),   32'(0));
    for (int i = 0; i < bytes.size(); i++) begin
      rx_byte  = bytes[i];
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_byte  = 8'($urandom);
      n = i + 1;
      if ((n % BPW) == 0 && (n / BPW) <= DEPTH) begin
        w = {bytes[n-3], bytes[n-2], bytes[n-1]};
        exp_mem[n/BPW - 1] = w;
        check_eq("wr_we",    32'(mem_we),     32'(1));
        check_eq("wr_addr",  32'(mem_waddr),  32'(n/BPW - 1));
        check_eq("wr_data",  32'(mem_wdata),  32'(w));
        check_eq("wr_count", 32'(word_count), 32'(n/BPW));
      end else begin
        check_eq("no_wr_we", 32'(mem_we), 32'(0));
      end
      if (n > BPW * DEPTH) check_eq("ovf_set", 32'(overflow), 32'(1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    n  = bytes.size();
    nw = (n / BPW > DEPTH) ? DEPTH : n / BPW;
    load_en = 1'b0;
    @(negedge clk);
    check_eq("load_exit_busy",  32'(busy),       32'(0));
    check_eq("load_exit_count", 32'(word_count), 32'(nw));
    check_eq("load_exit_ovf",   32'(overflow),   32'(n > BPW * DEPTH));
    exp_count = nw;
  endtask

  task automatic rand_bytes(input int n, output bq_t q);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  // Counts negedges until tx_valid; a stray tx_done is thrown in at k == 5.
  task automatic wait_valid(output int k);
    k = 0;
    while (!tx_valid && k < 2000) begin
      @(negedge clk);
      k++;
      tx_done = (k == 5);
    end
    tx_done = 1'b0;
  endtask

  task automatic spi_frame();
    repeat (SPI_BITS * SCK_DIV - 1) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic run_send(input bit bp);
    int k;
    tx_ready = !bp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("send_busy", 32'(busy), 32'(1));
    for (int i = 0; i < exp_count; i++) begin
      wait_valid(k);
      check_eq("tx_latency", 32'(k), (i == 0) ? 32'(3) : 32'(GAP + 3));
      check_eq("tx_data",    32'(tx_data),   32'(exp_mem[i]));
      check_eq("rd_addr",    32'(mem_raddr), 32'(i));
      if (bp) begin
        for (int c = 0; c < 10; c++) begin
          start = (c == 3);
          @(negedge clk);
          check_eq("bp_valid", 32'(tx_valid), 32'(1));
          check_eq("bp_data",  32'(tx_data),  32'(exp_mem[i]));
        end
        start    = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
      end else begin
        @(negedge clk);
      end
      check_eq("hs_valid_drop", 32'(tx_valid), 32'(0));
      spi_frame();
    end
    k = 0;
    while (!send_done && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq("done_latency", 32'(k),    32'(GAP));
    check_eq("done_busy",    32'(busy), 32'(0));
    @(negedge clk);
    check_eq("done_pulse",   32'(send_done), 32'(0));
    check_eq("idle_busy",    32'(busy),      32'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
  endtask

  initial begin
    bq_t q;
    int  k;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);

    // Two identical words, then a discarded partial word.
    q = {8'h55, 8'hAA, 8'h12, 8'h55, 8'hAA, 8'h12};
    load_session(q);
    q = {8'h11, 8'h22};
    load_session(q);
    rand_bytes(3, q);
    load_session(q);

    repeat (4) begin
      rand_bytes($urandom_range(0, 13), q);
      load_session(q);
    end
    rand_bytes(BPW * (DEPTH + 1), q);
    load_session(q);

    q = {8'h55, 8'hAA, 8'h12, 8'h55, 8'hAA, 8'h12, 8'h55, 8'hAA, 8'h12};
    load_session(q);
    run_send(1'b0);
    rand_bytes(9, q);
    load_session(q);
    run_send(1'b1);
    run_send(1'b0);

    // rx_valid outside LOAD is ignored.
    rx_byte  = 8'hA5;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check_eq("rx_idle_we",    32'(mem_we),     32'(0));
    check_eq("rx_idle_count", 32'(word_count), 32'(exp_count));

    // load_en and start together: load wins.
    load_en = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("prio_busy",  32'(busy),       32'(1));
    check_eq("prio_count", 32'(word_count), 32'(0));
    load_en = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("prio_idle",  32'(busy),     32'(0));
    check_eq("prio_no_tx", 32'(tx_valid), 32'(0));

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("start_empty_busy", 32'(busy), 32'(0));

    // Asynchronous reset while tx_valid is held.
    rand_bytes(3, q);
    load_session(q);
    tx_ready = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(k);
    check_eq("pre_rst_valid", 32'(tx_valid), 32'(1));
    #3 rst = 1'b1;
    #1;
    check_eq("async_valid", 32'(tx_valid), 32'(0));
    check_eq("async_busy",  32'(busy),     32'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;

    // Reset in WAITDONE.
    rand_bytes(6, q);
    load_session(q);
    tx_ready = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(k);
    @(negedge clk);
    check_eq("waitdone_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_wd");
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("post_rst_busy",  32'(busy),     32'(0));
    check_eq("post_rst_valid", 32'(tx_valid), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_scheduler.md
# spi_frame_scheduler

Sequencer between the UART receiver, the 24-bit frame memory and the SPI transmitter. While loading is enabled, it packs received UART bytes into 24-bit words and writes them to consecutive memory addresses. On a send command, it reads the words back in order and hands each one to the SPI transmitter over a valid/ready handshake, inserting a programmable inter-frame gap.

## Interface
Parameters:
- BYTES_PER_WORD, 3, UART bytes packed per memory word
- WORD_W, 24, memory/SPI word width (= 8*BYTES_PER_WORD)
- DEPTH, 16, memory words
- ADDR_W, 4, memory address width (clog2 DEPTH)
- GAP_CYCLES, 50, idle clk cycles between tx_done and the next tx_valid

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- load_en  in  1  level; high = accept UART bytes (debounced, polarity-corrected din_en)
- start  in  1  single-cycle send command (debounced start_sending edge)
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- rx_byte  in  8  received UART byte
- mem_we  out  1  memory write enable
- mem_waddr  out  ADDR_W  write address
- mem_wdata  out  WORD_W  write data
- mem_raddr  out  ADDR_W  read address
- mem_rdata  in  WORD_W  synchronous read data, valid one cycle after mem_raddr
- tx_valid  out  1  word available for SPI
- tx_data  out  WORD_W  word to shift out, MSB first
- tx_ready  in  1  SPI transmitter idle, accepts word when tx_valid & tx_ready
- tx_done  in  1  one-cycle strobe, SPI frame finished (cs_n released)
- word_count  out  ADDR_W+1  words stored in the current load session
- busy  out  1  high in any state other than IDLE
- send_done  out  1  one-cycle strobe, all stored words sent
- overflow  out  1  sticky, a byte was dropped because memory was full

## Operation
- States: IDLE, LOAD, RD, RDWAIT, XFER, WAITDONE, GAP.
- IDLE→LOAD on load_en high. Entry clears word_count, byte_idx and overflow.
- LOAD behavior:
  - Each rx_valid shifts rx_byte into the assembly register. The first byte lands in the MSBs: 0x55, 0xAA, 0x12 → 0x55AA12.
  - On the BYTES_PER_WORD-th byte, mem_we pulses for one cycle with mem_waddr = word_count and the assembled word. word_count increments on the same edge.
- LOAD→IDLE on load_en low. A partial word is discarded and byte_idx is cleared.
- Full memory: when word_count == DEPTH, further bytes are dropped, mem_we stays low and overflow is set.
- rx_valid is ignored outside LOAD.
- Send sequence:
  - IDLE→RD on start when word_count > 0. start is ignored in any other state or when word_count == 0.
  - RD: mem_raddr = rd_ptr (starts at 0).
  - RDWAIT: capture mem_rdata into tx_data.
  - XFER: tx_valid high, tx_data stable, until tx_valid & tx_ready.
  - WAITDONE: wait for tx_done.
  - GAP: count GAP_CYCLES, then increment rd_ptr.
  - After GAP: go to RD if rd_ptr < word_count. Otherwise pulse send_done and return to IDLE.
- Stored words persist after sending. A new start resends the same words; a new load session overwrites them.
- Reset outputs: mem_we 0, mem_waddr 0, mem_wdata 0, mem_raddr 0, tx_valid 0, tx_data 0, word_count 0, busy 0, send_done 0, overflow 0; state IDLE.
- rst mid-transfer: tx_valid drops immediately (async). The memory contents are not the block's responsibility.

## Timing
- Write: mem_we is asserted in the cycle after the rx_valid of the final byte. The word_count update is visible in that same cycle.
- Send latency:
  - start at edge N → mem_raddr driven after edge N+1.
  - tx_valid high after edge N+3.
- tx_valid stays high until the edge where tx_ready is sampled high. It deasserts after that edge.
- The handshake completes in the same cycle if tx_ready is already high.
- Next word: tx_valid is reasserted exactly GAP_CYCLES+3 cycles after the edge on which tx_done is sampled.
- send_done fires one cycle after the last GAP count expires. busy falls on that same edge.
- A tx_done received outside WAITDONE is ignored.
- Simultaneous events: load_en and start in the same cycle in IDLE → LOAD wins and start is dropped.

## Structure
- Shared package holds: the state enum, BYTES_PER_WORD/WORD_W defaults, and the GAP_CYCLES default derived from the SPI clock divider.
- Single sub-module: word_packer (byte_idx counter, shift register, word-complete strobe). The FSM, pointers and gap counter stay in spi_frame_scheduler.

## Test plan
- Basic load: load_en high, bytes 0x55, 0xAA, 0x12 twice, load_en low → two writes of 0x55AA12 at addresses 0 and 1; word_count = 2.
- Partial word: 2 bytes then load_en low, then a new session with 3 bytes → the partial is discarded; one write of the new word at address 0.
- Overflow: 17×3 bytes with DEPTH = 16 → 16 writes; overflow = 1; no write on the 17th word; word_count = 16.
- Send: 3 stored words, start, tx_ready tied high, tx_done modeled 24 SPI bits later → tx_data 0x55AA12 ×3 in address order; gaps ≥ GAP_CYCLES; one send_done; busy low afterwards.
- Backpressure and ignored commands: tx_ready low for 10 cycles → tx_valid and tx_data held stable. start with word_count = 0 → busy stays 0. start during XFER → ignored.
- Reset mid-send: rst asserted in WAITDONE → all outputs at reset values; after release, start with word_count = 0 does nothing.
